// File: rtl/tbec_stream_encoder.sv
// Multi-lane TBEC encoder: 16-bit words to 32-bit codewords behind a
// 2-entry valid/ready buffer, with fault-injection mask and saturating count.
module tbec_stream_encoder #(
   parameter int LANES = 2,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*LANES-1:0]   in_data,
   input  logic                  inj_en,
   input  logic [32*LANES-1:0]   inj_mask,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [32*LANES-1:0]   out_data,
   input  logic                  clr_count,
   output logic [CNT_W-1:0]      word_count
);

   localparam int DW = 32 * LANES;

   function automatic logic [31:0] tbec_enc(input logic [15:0] w);
      logic [3:0] a, b, c, e;
      logic [15:0] dat;
      logic [3:0] di, p;
      logic [7:0] x;
      a = w[15:12];
      b = w[11:8];
      c = w[7:4];
      e = w[3:0];
      dat = {a[3], b[3], c[3], e[3],
             a[2], b[2], c[2], e[2],
             a[1], b[1], c[1], e[1],
             a[0], b[0], c[0], e[0]};
      // di/p packed in codeword order: DI1 DI4 DI2 DI3, P1 P4 P2 P3
      di = {a[3] ^ b[2] ^ c[3] ^ e[2],
            a[0] ^ b[1] ^ c[0] ^ e[1],
            a[2] ^ b[3] ^ c[2] ^ e[3],
            a[1] ^ b[0] ^ c[1] ^ e[0]};
      p  = {a[3] ^ a[2] ^ b[3] ^ b[2],
            c[1] ^ c[0] ^ e[1] ^ e[0],
            c[3] ^ c[2] ^ e[3] ^ e[2],
            a[1] ^ a[0] ^ b[1] ^ b[0]};
      x  = {a[3] ^ a[1], a[2] ^ a[0],
            b[3] ^ b[1], b[2] ^ b[0],
            c[3] ^ c[1], c[2] ^ c[0],
            e[3] ^ e[1], e[2] ^ e[0]};
      return {dat, di, p, x};
   endfunction

   logic [DW-1:0]    mem_q [2];
   logic             wr_q;
   logic             rd_q;
   logic [1:0]       occ_q;
   logic [1:0]       occ_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W:0]   cnt_sum;
   logic [DW-1:0]    enc;
   logic [DW-1:0]    beat;
   logic             push;
   logic             pop;

   always_comb begin
      enc = '0;
      for (int l = 0; l < LANES; l++) begin
         enc[32*l +: 32] = tbec_enc(in_data[16*l +: 16]);
      end
   end

   assign beat      = enc ^ (inj_en ? inj_mask : '0);
   assign in_ready  = (occ_q != 2'd2);
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = mem_q[rd_q];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      occ_d = occ_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // Extra top bit of the sum flags overflow so the count clamps instead of wrapping
   always_comb begin
      cnt_d   = cnt_q;
      cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(LANES);
      if (clr_count) begin
         cnt_d = '0;
      end else if (pop) begin
         cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         occ_q    <= 2'd0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= beat;
            wr_q        <= ~wr_q;
         end
         if (pop) begin
            rd_q <= ~rd_q;
         end
         occ_q <= occ_d;
         cnt_q <= cnt_d;
      end
   end

   assign word_count = cnt_q;

endmodule

// File: doc/tbec_stream_encoder.md
Name: tbec_stream_encoder

Overview:
Multi-lane, streaming TBEC encoder. Each cycle it takes LANES independent 16-bit data words and produces LANES 32-bit TBEC codewords, using the fixed TBEC mapping (16 data + 4 diagonal + 4 parity + 8 check bits). A 2-entry output buffer with a valid/ready handshake decouples it from the memory write path. A fault-injection XOR mask supports ECC characterisation campaigns, and a saturating counter tracks emitted codewords.

Parameters:
LANES, 2, number of parallel 16-bit TBEC words per transfer (>=1)
CNT_W, 32, width of the emitted-codeword counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  encoder can accept a beat
in_data  in  16*LANES  lane i = in_data[16i+15:16i]
inj_en  in  1  apply inj_mask to the beat accepted this cycle
inj_mask  in  32*LANES  XOR mask applied to the codewords, same lane layout as out_data
out_valid  out  1  codeword beat valid
out_ready  in  1  consumer accepts beat
out_data  out  32*LANES  lane i = out_data[32i+31:32i]
clr_count  in  1  synchronous clear of word_count
word_count  out  CNT_W  number of codewords emitted (lane-words), saturating

Behaviour:
- Per-lane encode (combinational, per lane). For word d: A=d[15:12], B=d[11:8], C=d[7:4], D=d[3:0]. Index 1 is the nibble MSB (A1=d[15], A4=d[12]).
- DI1=A1^B2^C1^D2; DI2=A2^B1^C2^D1; DI3=A3^B4^C3^D4; DI4=A4^B3^C4^D3.
- P1=A1^A2^B1^B2; P2=C1^C2^D1^D2; P3=A3^A4^B3^B4; P4=C3^C4^D3^D4.
- Check bits: XA13=A1^A3, XA24=A2^A4; same pattern for B, C, D.
- Codeword bit order, bit 31 down to bit 0: A1 B1 C1 D1 A2 B2 C2 D2 A3 B3 C3 D3 A4 B4 C4 D4 DI1 DI4 DI2 DI3 P1 P4 P2 P3 XA13 XA24 XB13 XB24 XC13 XC24 XD13 XD24.
- Accept occurs when in_valid && in_ready. The stored beat is encode(in_data) ^ (inj_en ? inj_mask : 0). inj_en and inj_mask are sampled only on accept and are ignored otherwise.
- Buffer: 2-entry FIFO, occupancy 0..2.
  - in_ready = (occupancy != 2). This is combinational from state only, with no dependence on out_ready.
  - out_valid = (occupancy != 0). out_data = head entry.
  - Pop occurs when out_valid && out_ready.
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N when the buffer was empty. Sustained throughput is 1 beat/cycle while out_ready=1.
- Simultaneous push and pop at occupancy 1: occupancy stays 1, and the new beat becomes head after the edge. Push at occupancy 2 cannot occur because in_ready=0.
- out_data is held stable while out_valid && !out_ready; order is strictly FIFO.
- word_count:
  - Each pop adds LANES. It saturates at 2^CNT_W-1; on overflow it clamps to max and does not wrap.
  - clr_count has priority over a same-cycle increment; the result is 0.
- Reset (rst_n low, asynchronous): occupancy=0, out_valid=0, out_data=0, storage=0, word_count=0. in_ready reads 1 during and after reset. Any handshake while rst_n=0 has no effect. Reset mid-stream discards buffered beats, and no partial beat is emitted afterwards.
- No X propagation: unused storage entries reset to 0.

Test Plan:
1. LANES=1, in_data=16'hFFFF, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF0000, word_count=1.
2. in_data=16'h8000 -> out_data=32'h80008880. in_data=16'h0001 -> out_data=32'h00011401. Also run 10k random words against a bit-level reference model for LANES=1,2,4.
3. Backpressure: out_ready=0, push 3 beats 0x0001, 0x8000, 0xFFFF -> in_ready drops after 2 accepts and out_data holds 32'h00011401. Then raise out_ready -> outputs 00011401, 80008880, FFFF0000 in order, with no loss or duplication.
4. Injection: in_data=16'hFFFF, inj_en=1, inj_mask=32'h00000001 -> out_data=32'hFFFF0001. A mask applied on a non-accept cycle has no effect.
5. Counter: CNT_W=4, LANES=2, 8 pops -> word_count=15 (saturated). clr_count asserted together with a pop -> 0.
6. Reset mid-stream: occupancy 2, drop rst_n asynchronously mid-cycle -> out_valid=0, out_data=0, word_count=0 immediately. After release, the first accepted beat is the first emitted.
